// File: rtl/clock_gen.sv
// clock_gen: NUM_CH independent programmable clock dividers producing 50% square waves and toggle ticks.
// Latency: clk_out/tick are registered; a divisor write takes effect from the edge after the write.
// Backpressure: none; en[i] low freezes a channel in place, and div_wr is a fire-and-forget strobe.
//
// Ports:
//   CLK      system clock, all logic on posedge
//   reset    asynchronous active-high reset (cnt=0, div=DIV_DEFAULT, outputs 0)
//   en       per-channel run enable
//   div_wr   one-cycle divisor write strobe; div_sel picks the channel, div_val the divisor
//   sync     (only with CLOCK_GEN_SYNC_EN) synchronous phase-align: clears cnt/clk_out/tick, keeps div
//   clk_out  per-channel divided clock, period 2*(div+1) CLK cycles
//   tick     per-channel one-cycle pulse on every clk_out toggle
//
// Optional feature macro: CLOCK_GEN_SYNC_EN (adds the sync input and its clear logic).
module clock_gen #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 20,
  parameter int DIV_DEFAULT = 500000
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr,
  input  logic [3:0]        div_sel,
  input  logic [CNT_W-1:0]  div_val,
`ifdef CLOCK_GEN_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic             clk_q;
    logic             tick_q;
    logic             wr_hit;
    logic             terminal;

    // div_sel values at or above NUM_CH never match any channel, so such writes vanish.
    assign wr_hit   = div_wr && (div_sel == 4'(i));
    // '>=' rather than '==': a divisor shrunk below the running count ends the
    // period on the next edge instead of letting the counter wrap.
    assign terminal = (cnt >= div);

    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        cnt    <= '0;
        div    <= DIV_RST;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        // The terminal test below reads the old div, so a new value governs from the next edge.
        if (wr_hit) begin
          div <= div_val;
        end
`ifdef CLOCK_GEN_SYNC_EN
        if (sync) begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else
`endif
        if (en[i]) begin
          if (terminal) begin
            cnt    <= '0;
            clk_q  <= ~clk_q;
            tick_q <= 1'b1;
          end else begin
            cnt    <= cnt + CNT_ONE;
            tick_q <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: doc/clock_gen.md
CLOCK_GEN -- requirements
Module: clock_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 20: width of each channel's counter and divisor.
REQ-003 SHALL have parameter DIV_DEFAULT, default 500000: divisor loaded into every channel at reset.
REQ-004 SHALL have port CLK  input  1: single system clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port en  input  NUM_CH: per-channel run enable.
REQ-007 SHALL have port div_wr  input  1: divisor write strobe, one cycle.
REQ-008 SHALL have port div_sel  input  4: channel index for div_wr.
REQ-009 SHALL have port div_val  input  CNT_W: divisor value for div_wr.
REQ-010 SHALL have port clk_out  output  NUM_CH: per-channel divided square wave, registered.
REQ-011 SHALL have port tick  output  NUM_CH: per-channel one-cycle pulse on each clk_out toggle, registered.

Function
REQ-012 Each channel SHALL hold a counter cnt[i] and a divisor div[i], both CNT_W bits, unsigned.
REQ-013 When en[i]=1 and cnt[i] >= div[i], the channel SHALL load cnt[i]=0, invert clk_out[i], and drive tick[i]=1 in the same edge.
REQ-014 When en[i]=1 and cnt[i] < div[i], the channel SHALL increment cnt[i] by 1 and drive tick[i]=0.
REQ-015 With en[i]=1 held, clk_out[i] SHALL have period 2*(div[i]+1) CLK cycles and 50% duty cycle; tick[i] SHALL pulse every div[i]+1 cycles.
REQ-016 div[i]=0 SHALL give clk_out[i] toggling every cycle and tick[i] held high continuously.
REQ-017 When en[i]=0, cnt[i] and clk_out[i] SHALL hold their values and tick[i] SHALL be 0; on re-enable, counting SHALL resume from the held cnt[i].
REQ-018 div_wr=1 with div_sel < NUM_CH SHALL write div_val into div[div_sel] at that edge; div_wr with div_sel >= NUM_CH SHALL be ignored.
REQ-019 The terminal test at the write edge SHALL use the old divisor; the new divisor SHALL govern from the following edge.
REQ-020 If a write makes div[i] < cnt[i], the next enabled edge SHALL take the terminal path (REQ-013), with no counter wrap through 2^CNT_W.
REQ-021 Counter arithmetic SHALL never overflow: cnt[i] <= max(div[i], previous cnt) at all times.
REQ-022 Channels SHALL be fully independent; a write to one channel SHALL not disturb cnt, div, clk_out, or tick of any other channel.

Reset
REQ-023 reset=1 SHALL asynchronously force cnt=0, div=DIV_DEFAULT, clk_out=0, and tick=0 on all channels, regardless of CLK.
REQ-024 reset asserted mid-period SHALL abort the period; after deassertion, the first toggle SHALL occur DIV_DEFAULT+1 enabled cycles later.
REQ-025 div_wr during reset SHALL be ignored.

Configuration
REQ-026 Macro CLOCK_GEN_SYNC_EN defined SHALL add input port sync (1 bit); sync=1 SHALL synchronously clear cnt, clk_out, and tick on all channels, keep div, and take priority over en and the terminal test, phase-aligning all channels.
REQ-027 Macro CLOCK_GEN_SYNC_EN undefined SHALL remove the sync port and all associated logic; behaviour SHALL be exactly REQ-012..REQ-025.

Verification
REQ-028 Reset release, en=2'b11, default divisor, NUM_CH=2 -> first clk_out rise at cycle 500001, tick pulses at cycles 500001 and 1000002, period 1000002 cycles.
REQ-029 Write div_sel=0, div_val=3 -> ch0 clk_out period 8 cycles with tick every 4 cycles; ch1 unchanged.
REQ-030 ch0 at cnt=10, write div_val=4 -> terminal path on the next edge, cnt returns to 0, no wrap.
REQ-031 en[0] low for 7 cycles mid-count -> cnt and clk_out frozen, tick 0, period stretched by exactly 7 cycles.
REQ-032 Write div_sel=5 with NUM_CH=2 -> no divisor changes; reset pulse asserted between CLK edges -> outputs 0 immediately.
REQ-033 With CLOCK_GEN_SYNC_EN, divisors 3 and 5, pulse sync -> both clk_out=0 and cnt=0 on the next edge; first ticks 4 and 6 cycles later.
